// File: rtl/rat_ckpt_pkg.sv
// Shared parameters, entry types and CDB wakeup helpers for the rename table
// and its branch checkpoint bank.
package rat_ckpt_pkg;

  localparam int PR_WIDTH  = 6;
  localparam int AR_COUNT  = 32;
  localparam int AR_WIDTH  = $clog2(AR_COUNT);
  localparam int NUM_READ  = 2;
  localparam int NUM_CDB   = 4;
  localparam int NUM_CKPT  = 4;
  localparam int CK_WIDTH  = $clog2(NUM_CKPT);
  localparam int CNT_WIDTH = CK_WIDTH + 1;

  typedef struct packed {
    logic [PR_WIDTH-1:0] pr;
    logic                rdy;
  } rat_entry_t;

  typedef struct packed {
    logic                we;
    logic [AR_WIDTH-1:0] rd;
    logic [PR_WIDTH-1:0] pd;
  } cdb_wake_t;

  typedef rat_entry_t [AR_COUNT-1:0] rat_map_t;
  typedef cdb_wake_t  [NUM_CDB-1:0]  cdb_bus_t;

  // A broadcast only wakes an entry whose current tag matches; stale tags are ignored.
  function automatic logic cdb_hit(input logic [AR_WIDTH-1:0] ar,
                                   input logic [PR_WIDTH-1:0] pr,
                                   input cdb_bus_t            cdb);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < NUM_CDB; j++) begin
      if (cdb[j].we && (cdb[j].rd == ar) && (cdb[j].pd == pr)) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic rat_map_t wake_map(input rat_map_t m, input cdb_bus_t cdb);
    rat_map_t w;
    w = m;
    for (int i = 0; i < AR_COUNT; i++) begin
      w[i].rdy = m[i].rdy | cdb_hit(AR_WIDTH'(i), m[i].pr, cdb);
    end
    return w;
  endfunction

endpackage

// File: rtl/rat_ckpt_if.sv
// Rename/checkpoint bus between decode (master) and the alias table (slave).
interface rat_ckpt_if;
  import rat_ckpt_pkg::*;

  logic                               rat_we_i;
  logic [AR_WIDTH-1:0]                rd_i;
  logic [PR_WIDTH-1:0]                pd_i;
  logic [NUM_READ-1:0][AR_WIDTH-1:0]  rs_i;
  logic [NUM_READ-1:0][PR_WIDTH-1:0]  ps_o;
  logic [NUM_READ-1:0]                ps_valid_o;
  logic [NUM_CDB-1:0]                 cdb_we_i;
  logic [NUM_CDB-1:0][AR_WIDTH-1:0]   cdb_rd_i;
  logic [NUM_CDB-1:0][PR_WIDTH-1:0]   cdb_pd_i;
  logic                               ckpt_take_i;
  logic [CK_WIDTH-1:0]                ckpt_id_o;
  logic                               ckpt_full_o;
  logic                               ckpt_release_i;
  logic                               ckpt_restore_i;
  logic [CK_WIDTH-1:0]                restore_id_i;
  logic                               flush_i;
  logic [AR_COUNT-1:0][PR_WIDTH-1:0]  rrf_rdata_i;

  modport master (
    output rat_we_i, rd_i, pd_i, rs_i, cdb_we_i, cdb_rd_i, cdb_pd_i,
           ckpt_take_i, ckpt_release_i, ckpt_restore_i, restore_id_i,
           flush_i, rrf_rdata_i,
    input  ps_o, ps_valid_o, ckpt_id_o, ckpt_full_o
  );

  modport slave (
    input  rat_we_i, rd_i, pd_i, rs_i, cdb_we_i, cdb_rd_i, cdb_pd_i,
           ckpt_take_i, ckpt_release_i, ckpt_restore_i, restore_id_i,
           flush_i, rrf_rdata_i,
    output ps_o, ps_valid_o, ckpt_id_o, ckpt_full_o
  );

endinterface

// File: rtl/rat_ckpt_snapshot_bank.sv
// Checkpoint storage: one full map snapshot per slot, each slot kept current
// by tag-checked CDB wakeups while it is live.
module rat_snapshot_bank
  import rat_ckpt_pkg::*;
(
  input  logic                clk,
  input  logic                wr_en_i,
  input  logic [CK_WIDTH-1:0] wr_slot_i,
  input  rat_map_t            wr_map_i,
  input  logic [NUM_CKPT-1:0] live_i,
  input  cdb_bus_t            cdb_i,
  input  logic [CK_WIDTH-1:0] rd_slot_i,
  output rat_map_t            rd_map_o
);

  rat_map_t slot_view [NUM_CKPT];

  generate
    for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_slot
      rat_map_t slot_q;

      // The write data already carries this cycle's wakeups, so it wins.
      always_ff @(posedge clk) begin
        if (wr_en_i && (wr_slot_i == CK_WIDTH'(gi))) begin
          slot_q <= wr_map_i;
        end else if (live_i[gi]) begin
          slot_q <= wake_map(slot_q, cdb_i);
        end
      end

      assign slot_view[gi] = slot_q;
    end
  endgenerate

  assign rd_map_o = slot_view[rd_slot_i];

endmodule

// File: rtl/rat_ckpt.sv
// Register alias table with ready bits, CDB wakeup, branch checkpoints for
// single-cycle mispredict recovery and full flush from the retirement RAT.
module rat_ckpt
  import rat_ckpt_pkg::*;
(
  input logic      clk,
  input logic      rst_n,
  rat_ckpt_if.slave bus
);

  rat_map_t             map_q, map_d, snap_map;
  logic [CK_WIDTH-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 full_q;
  logic                 release_ok, take_ok;
  logic [CK_WIDTH-1:0]  restore_dist;
  logic [NUM_CKPT-1:0]  live;
  cdb_bus_t             cdb;

  always_comb begin
    cdb = '0;
    for (int j = 0; j < NUM_CDB; j++) begin
      cdb[j].we = bus.cdb_we_i[j];
      cdb[j].rd = bus.cdb_rd_i[j];
      cdb[j].pd = bus.cdb_pd_i[j];
    end
  end

  // Same-cycle rename is not forwarded; only CDB results bypass into ps_valid.
  generate
    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_read
      rat_entry_t ent;
      assign ent                = map_q[bus.rs_i[gi]];
      assign bus.ps_o[gi]       = ent.pr;
      assign bus.ps_valid_o[gi] = (bus.rs_i[gi] == '0) || ent.rdy ||
                                  cdb_hit(bus.rs_i[gi], ent.pr, cdb);
    end

    for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_live
      logic [CK_WIDTH-1:0] age;
      assign age      = CK_WIDTH'(gi) - head_q;
      assign live[gi] = CNT_WIDTH'(age) < count_q;
    end
  endgenerate

  always_comb begin
    release_ok   = bus.ckpt_release_i && (count_q != '0);
    take_ok      = bus.ckpt_take_i && (!full_q || release_ok) &&
                   !bus.ckpt_restore_i && !bus.flush_i;
    restore_dist = bus.restore_id_i - head_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    if (bus.flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (bus.ckpt_restore_i) begin
      head_d  = head_q + CK_WIDTH'(release_ok);
      tail_d  = bus.restore_id_i + CK_WIDTH'(1);
      count_d = CNT_WIDTH'(restore_dist) + CNT_WIDTH'(1) - CNT_WIDTH'(release_ok);
    end else begin
      head_d  = head_q + CK_WIDTH'(release_ok);
      tail_d  = tail_q + CK_WIDTH'(take_ok);
      count_d = count_q + CNT_WIDTH'(take_ok) - CNT_WIDTH'(release_ok);
    end
  end

  always_comb begin
    map_d = wake_map(map_q, cdb);
    if (bus.flush_i) begin
      for (int i = 0; i < AR_COUNT; i++) begin
        map_d[i] = '{pr: bus.rrf_rdata_i[i], rdy: 1'b1};
      end
    end else if (bus.ckpt_restore_i) begin
      map_d = wake_map(snap_map, cdb);
    end else if (bus.rat_we_i && (bus.rd_i != '0)) begin
      map_d[bus.rd_i] = '{pr: bus.pd_i, rdy: 1'b0};
    end
  end

  // A take captures the post-rename, post-wakeup map so a link write survives recovery.
  rat_snapshot_bank u_bank (
    .clk       (clk),
    .wr_en_i   (take_ok),
    .wr_slot_i (tail_q),
    .wr_map_i  (map_d),
    .live_i    (live),
    .cdb_i     (cdb),
    .rd_slot_i (bus.restore_id_i),
    .rd_map_o  (snap_map)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < AR_COUNT; i++) begin
        map_q[i] <= '{pr: PR_WIDTH'(i), rdy: 1'b1};
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      map_q   <= map_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= (count_d == CNT_WIDTH'(NUM_CKPT));
    end
  end

  assign bus.ckpt_id_o   = tail_q;
  assign bus.ckpt_full_o = full_q;

endmodule

// File: tb/tb_rat_ckpt.sv
// Directed bench for rat_ckpt: rename, wakeup, checkpoint take/release/restore,
// flush and asynchronous reset, with hand-computed expectations.
module tb_rat_ckpt;
  import rat_ckpt_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  rat_ckpt_if bus ();

  rat_ckpt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rat_we_i       = 1'b0;
    bus.rd_i           = '0;
    bus.pd_i           = '0;
    bus.cdb_we_i       = '0;
    bus.cdb_rd_i       = '0;
    bus.cdb_pd_i       = '0;
    bus.ckpt_take_i    = 1'b0;
    bus.ckpt_release_i = 1'b0;
    bus.ckpt_restore_i = 1'b0;
    bus.restore_id_i   = '0;
    bus.flush_i        = 1'b0;
  endtask

  task automatic rename(input logic [AR_WIDTH-1:0] rd, input logic [PR_WIDTH-1:0] pd);
    bus.rat_we_i = 1'b1;
    bus.rd_i     = rd;
    bus.pd_i     = pd;
  endtask

  task automatic cdb_drive(input int lane, input logic [AR_WIDTH-1:0] rd,
                           input logic [PR_WIDTH-1:0] pd);
    bus.cdb_we_i[lane] = 1'b1;
    bus.cdb_rd_i[lane] = rd;
    bus.cdb_pd_i[lane] = pd;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle();
    bus.rs_i        = '0;
    bus.rrf_rdata_i = '0;
    repeat (2) tick();
    rst_n = 1'b1;

    // Reset state and identity map
    bus.rs_i[0] = 5;
    bus.rs_i[1] = 0;
    #1;
    chk("rst_ps0", 32'(bus.ps_o[0]), 5);
    chk("rst_ps1", 32'(bus.ps_o[1]), 0);
    chk("rst_valid", 32'(bus.ps_valid_o), 3);
    chk("rst_full", 32'(bus.ckpt_full_o), 0);
    chk("rst_id", 32'(bus.ckpt_id_o), 0);

    // Rename, x0 drop, stale and matching CDB wakeup
    rename(3, 40);
    tick();
    idle();
    bus.rs_i[0] = 3;
    #1;
    chk("ren_ps", 32'(bus.ps_o[0]), 40);
    chk("ren_notready", 32'(bus.ps_valid_o[0]), 0);
    rename(0, 60);
    tick();
    idle();
    #1;
    chk("x0_ps", 32'(bus.ps_o[1]), 0);
    chk("x0_valid", 32'(bus.ps_valid_o[1]), 1);
    cdb_drive(2, 3, 12);
    #1;
    chk("stale_bypass", 32'(bus.ps_valid_o[0]), 0);
    tick();
    idle();
    #1;
    chk("stale_ready", 32'(bus.ps_valid_o[0]), 0);
    cdb_drive(2, 3, 40);
    #1;
    chk("cdb_bypass", 32'(bus.ps_valid_o[0]), 1);
    tick();
    idle();
    #1;
    chk("cdb_ready", 32'(bus.ps_valid_o[0]), 1);

    // Two checkpoints, then restore the older one
    bus.ckpt_take_i = 1'b1;
    tick();
    idle();
    #1;
    chk("take0_id", 32'(bus.ckpt_id_o), 1);
    rename(3, 41);
    tick();
    idle();
    bus.ckpt_take_i = 1'b1;
    tick();
    idle();
    #1;
    chk("take1_id", 32'(bus.ckpt_id_o), 2);
    rename(3, 42);
    tick();
    idle();
    #1;
    chk("young_ps", 32'(bus.ps_o[0]), 42);
    chk("young_valid", 32'(bus.ps_valid_o[0]), 0);
    bus.ckpt_restore_i = 1'b1;
    bus.restore_id_i   = 0;
    rename(9, 33);
    tick();
    idle();
    bus.rs_i[1] = 9;
    #1;
    chk("rest_ps", 32'(bus.ps_o[0]), 40);
    chk("rest_valid", 32'(bus.ps_valid_o[0]), 1);
    chk("rest_id", 32'(bus.ckpt_id_o), 1);
    chk("rest_full", 32'(bus.ckpt_full_o), 0);
    chk("rest_ren_ignored", 32'(bus.ps_o[1]), 9);

    // Release the survivor (count 1 -> 0), fill all four slots, overflow, release+take
    bus.ckpt_release_i = 1'b1;
    tick();
    idle();
    bus.ckpt_take_i = 1'b1;
    repeat (3) tick();
    idle();
    #1;
    chk("fill3_full", 32'(bus.ckpt_full_o), 0);
    chk("fill3_id", 32'(bus.ckpt_id_o), 0);
    bus.ckpt_take_i = 1'b1;
    tick();
    idle();
    #1;
    chk("fill4_full", 32'(bus.ckpt_full_o), 1);
    chk("fill4_id", 32'(bus.ckpt_id_o), 1);
    bus.ckpt_take_i = 1'b1;
    tick();
    idle();
    #1;
    chk("over_full", 32'(bus.ckpt_full_o), 1);
    chk("over_id", 32'(bus.ckpt_id_o), 1);
    bus.ckpt_take_i    = 1'b1;
    bus.ckpt_release_i = 1'b1;
    tick();
    idle();
    #1;
    chk("reltake_full", 32'(bus.ckpt_full_o), 1);
    chk("reltake_id", 32'(bus.ckpt_id_o), 2);

    // Snapshot x7->p50 woken by CDB while a younger rename maps x7->p51
    bus.ckpt_release_i = 1'b1;
    tick();
    idle();
    #1;
    chk("rel_full", 32'(bus.ckpt_full_o), 0);
    rename(7, 50);
    tick();
    idle();
    bus.ckpt_take_i = 1'b1;
    tick();
    idle();
    #1;
    chk("snap_full", 32'(bus.ckpt_full_o), 1);
    chk("snap_id", 32'(bus.ckpt_id_o), 3);
    rename(7, 51);
    cdb_drive(1, 7, 50);
    bus.rs_i[0] = 7;
    #1;
    chk("wake_ps", 32'(bus.ps_o[0]), 50);
    chk("wake_bypass", 32'(bus.ps_valid_o[0]), 1);
    tick();
    idle();
    #1;
    chk("over_ps", 32'(bus.ps_o[0]), 51);
    chk("over_valid", 32'(bus.ps_valid_o[0]), 0);
    bus.ckpt_restore_i = 1'b1;
    bus.restore_id_i   = 2;
    tick();
    idle();
    #1;
    chk("snapw_ps", 32'(bus.ps_o[0]), 50);
    chk("snapw_valid", 32'(bus.ps_valid_o[0]), 1);
    chk("snapw_full", 32'(bus.ckpt_full_o), 1);
    chk("snapw_id", 32'(bus.ckpt_id_o), 3);

    // Flush wins over a same-cycle restore and rename
    for (int i = 0; i < AR_COUNT; i++) bus.rrf_rdata_i[i] = 6'(i + 32);
    bus.flush_i        = 1'b1;
    bus.ckpt_restore_i = 1'b1;
    bus.restore_id_i   = 1;
    rename(5, 9);
    tick();
    idle();
    bus.rs_i[0] = 5;
    bus.rs_i[1] = 7;
    #1;
    chk("flush_ps0", 32'(bus.ps_o[0]), 37);
    chk("flush_ps1", 32'(bus.ps_o[1]), 39);
    chk("flush_valid", 32'(bus.ps_valid_o), 3);
    chk("flush_full", 32'(bus.ckpt_full_o), 0);
    chk("flush_id", 32'(bus.ckpt_id_o), 0);
    bus.ckpt_take_i = 1'b1;
    repeat (4) tick();
    idle();
    #1;
    chk("postflush_full", 32'(bus.ckpt_full_o), 1);
    chk("postflush_id", 32'(bus.ckpt_id_o), 0);

    // Asynchronous reset while a flush is pending
    bus.flush_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ps0", 32'(bus.ps_o[0]), 5);
    chk("arst_ps1", 32'(bus.ps_o[1]), 7);
    chk("arst_valid", 32'(bus.ps_valid_o), 3);
    chk("arst_full", 32'(bus.ckpt_full_o), 0);
    chk("arst_id", 32'(bus.ckpt_id_o), 0);
    idle();
    #1;
    rst_n = 1'b1;
    tick();
    #1;
    chk("arst_hold_ps0", 32'(bus.ps_o[0]), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
